// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - word-addressed load/store responder with fixed wait states
// Three-state IDLE/WAIT/RESP handshake in front of a 2^ADDR_W x 32-bit storage array.
module data_memory_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int         LP_DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] LP_CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic       LP_NO_WAIT  = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_write;
    logic                r_err;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_error;
    logic [31:0]         r_mem [LP_DEPTH];

    logic                w_in_err;
    logic [ADDR_W-1:0]   w_in_idx;
    logic                w_accept;
    logic                w_enter_resp;
    logic                w_c_write;
    logic                w_c_err;
    logic [ADDR_W-1:0]   w_c_idx;
    logic [31:0]         w_c_wdata;
    logic                w_mem_we;
    logic [31:0]         w_rd_word;

    assign w_in_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_W + 2)) != 32'd0);
    assign w_in_idx = req_addr[ADDR_W+1:2];
    assign w_accept = (r_state == S_IDLE) && req_valid;

    // With no wait states the commit happens on the accepting edge, so the
    // committed request comes straight from the inputs instead of the latches.
    assign w_c_write = (r_state == S_IDLE) ? req_write : r_write;
    assign w_c_err   = (r_state == S_IDLE) ? w_in_err  : r_err;
    assign w_c_idx   = (r_state == S_IDLE) ? w_in_idx  : r_idx;
    assign w_c_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_enter_resp = !reset &&
                          ((w_accept && LP_NO_WAIT) || ((r_state == S_WAIT) && (r_cnt == 4'd0)));
    assign w_mem_we     = w_enter_resp && w_c_write && !w_c_err;
    assign w_rd_word    = (!w_c_write && !w_c_err) ? r_mem[w_c_idx] : 32'd0;

    // Storage is deliberately outside the reset domain; only the gated write touches it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_c_idx] <= w_c_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= 32'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_err       <= w_in_err;
                        r_idx       <= w_in_idx;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (LP_NO_WAIT) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_rd_word;
                            r_resp_error <= w_c_err;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= LP_CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_rd_word;
                        r_resp_error <= w_c_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_resp_error <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= 4'd0;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= 32'd0;
                    r_resp_error <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_error = r_resp_error;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed vector bench for data_memory_responder
// Instance a uses two wait states, instance b none.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_req_valid, a_req_write, a_req_ready, a_resp_valid, a_resp_ready, a_resp_error;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        b_req_valid, b_req_write, b_req_ready, b_resp_valid, b_resp_ready, b_resp_error;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_ready(a_req_ready),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_error(a_resp_error)
    );

    data_memory_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_ready(b_req_ready),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_error(b_resp_error)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns the response and the edges from acceptance to resp_valid.
    task automatic xact(input logic w, input logic [31:0] addr, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
        int n;
        n = 0;
        while (!a_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        a_req_write = w;
        a_req_addr  = addr;
        a_req_wdata = d;
        a_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        lat = 0;
        while (!a_resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = a_resp_rdata;
        e  = a_resp_error;
        a_resp_ready = 1'b1;
        @(negedge clk);
        a_resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1};
        vecs[3]  = '{1'b1, 32'h0000_0011, 32'h1234_5678, 32'h0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0400, 32'h1111_1111, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[10] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_0020, 32'h0000_0055, 32'h0, 1'b0};

        reset = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(a_req_ready), 32'd1);
        check("reset_resp_valid", 32'(a_resp_valid), 32'd0);
        check("reset_resp_rdata", a_resp_rdata, 32'd0);
        check("reset_resp_error", 32'(a_resp_error), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            xact(vecs[i].write, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        // Response held for five cycles while a store to the same word is offered.
        a_req_write = 1'b0; a_req_addr = 32'h10; a_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        n = 0;
        while (!a_resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        a_req_write = 1'b1; a_req_addr = 32'h10; a_req_wdata = 32'h0; a_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_valid", k), 32'(a_resp_valid), 32'd1);
            check($sformatf("hold%0d_rdata", k), a_resp_rdata, 32'hDEAD_BEEF);
            check($sformatf("hold%0d_error", k), 32'(a_resp_error), 32'd0);
            check($sformatf("hold%0d_req_ready", k), 32'(a_req_ready), 32'd0);
            @(negedge clk);
        end
        a_resp_ready = 1'b1;
        @(negedge clk);
        check("complete_no_accept_ready", 32'(a_req_ready), 32'd1);
        check("complete_no_accept_valid", 32'(a_resp_valid), 32'd0);
        a_req_valid = 1'b0;
        a_resp_ready = 1'b0;
        xact(1'b0, 32'h10, 32'h0, rd, er, lat);
        check("hold_ignored_store_rdata", rd, 32'hDEAD_BEEF);

        // Reset on the edge that would commit a store.
        a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'hAA; a_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        check("wait_req_ready", 32'(a_req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_req_ready", 32'(a_req_ready), 32'd1);
        check("abort_resp_valid", 32'(a_resp_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_late_resp", 32'(a_resp_valid), 32'd0);
        xact(1'b0, 32'h20, 32'h0, rd, er, lat);
        check("abort_store_dropped", rd, 32'h0000_0055);
        check("abort_load_latency", 32'(lat), 32'd2);

        // Zero wait states, back-to-back with resp_ready tied high.
        b_resp_ready = 1'b1;
        b_req_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ea;
            logic [31:0] ed;
            logic        ew;
            case (i)
                0: begin ew = 1'b1; ea = 32'h40; ed = 32'h0102_0304; end
                1: begin ew = 1'b1; ea = 32'h44; ed = 32'h0A0B_0C0D; end
                2: begin ew = 1'b0; ea = 32'h40; ed = 32'h0102_0304; end
                default: begin ew = 1'b0; ea = 32'h44; ed = 32'h0A0B_0C0D; end
            endcase
            b_req_write = ew;
            b_req_addr  = ea;
            b_req_wdata = ew ? ed : 32'h0;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b%0d_valid", i), 32'(b_resp_valid), 32'd1);
            check($sformatf("b2b%0d_rdata", i), b_resp_rdata, ew ? 32'h0 : ed);
            check($sformatf("b2b%0d_error", i), 32'(b_resp_error), 32'd0);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!b_req_ready && n < 10);
            check($sformatf("b2b%0d_spacing", i), 32'(n), 32'd1);
        end
        b_req_valid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
